// File: rtl/add_nb_seq.sv
`timescale 1ns/1ps
// Multi-cycle add/sub, CHUNK bits per cycle; optional signed saturation via ADD_SAT_EN.
// Latency: out_valid NCHUNK edges after accept; one result per NCHUNK+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE.
module add_nb_seq #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [CHUNK:0]   csum;
    logic [WIDTH-1:0] res_nxt;
    logic             ovf_nxt;

    // out doubles as the partial-result register while the ripple runs
    always_comb begin
        csum    = {1'b0, a_q[cnt*CHUNK +: CHUNK]}
                + {1'b0, b_q[cnt*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, carry};
        res_nxt = out;
        res_nxt[cnt*CHUNK +: CHUNK] = csum[CHUNK-1:0];
        ovf_nxt = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_nxt[WIDTH-1] != a_q[WIDTH-1]);
    end

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            out   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= x;
                        b_q   <= y ^ {WIDTH{sub}};
                        carry <= sub;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    out   <= res_nxt;
                    carry <= csum[CHUNK];
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= DONE;
                        cnt   <= '0;
                        cout  <= csum[CHUNK];
                        ovf   <= ovf_nxt;
`ifdef ADD_SAT_EN
                        // clamp toward the sign of A; flags keep the wrapped result
                        if (ovf_nxt)
                            out <= {a_q[WIDTH-1], {(WIDTH-1){~a_q[WIDTH-1]}}};
`endif
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add_nb_seq.sv
`timescale 1ns/1ps
// Self-checking bench for add_nb_seq: vector table, handshake corners, random stream vs arithmetic model.
module tb_add_nb_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, sub, out_valid, out_ready, cout, ovf;
    logic [7:0] x, y, out;

    logic        w_in_valid, w_in_ready, w_sub, w_out_valid, w_out_ready, w_cout, w_ovf;
    logic [15:0] w_x, w_y, w_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    add_nb_seq #(.WIDTH(8), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .cout(cout), .ovf(ovf)
    );

    add_nb_seq #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .x(w_x), .y(w_y), .sub(w_sub), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out(w_out), .cout(w_cout), .ovf(w_ovf)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       s;
        logic [7:0] eo;
        logic       ec;
        logic       ev;
    } vec_t;

    typedef struct {
        logic [7:0] o;
        logic       c;
        logic       v;
    } res_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views of the operands
    function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic s);
        res_t r;
        int ua, ub, sa, sb, ur, sr;
        ua = a; ub = b;
        sa = $signed(a); sb = $signed(b);
        if (s) begin
            ur = ua - ub; r.c = (ua >= ub); sr = sa - sb;
        end else begin
            ur = ua + ub; r.c = (ur > 255); sr = sa + sb;
        end
        r.o = ur[7:0];
        r.v = (sr > 127) || (sr < -128);
`ifdef ADD_SAT_EN
        if (r.v) r.o = (sr > 127) ? 8'h7F : 8'h80;
`endif
        return r;
    endfunction

    task automatic wait_vld(output int n);
        n = 0;
        while (!out_valid && n < 30) begin
            @(posedge clk); #1; n++;
        end
        chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    // Called at #1 after an edge with the DUT idle
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic [7:0] eo, input logic ec, input logic ev,
                         input int hold, input string nm);
        int n;
        in_valid = 1'b1; x = a; y = b; sub = s; out_ready = (hold == 0);
        chk({nm, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; x = 8'($urandom); y = 8'($urandom); sub = 1'($urandom);
        wait_vld(n);
        chk({nm, "_latency"}, n, 32'd2);
        chk({nm, "_out"}, {24'd0, out}, {24'd0, eo});
        chk({nm, "_cout"}, {31'd0, cout}, {31'd0, ec});
        chk({nm, "_ovf"}, {31'd0, ovf}, {31'd0, ev});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({nm, "_hold"}, {23'd0, out_valid, out}, {23'd0, 1'b1, eo});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({nm, "_vld_drop"}, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic do16(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic [15:0] eo, input logic ec, input logic ev, input string nm);
        int n;
        w_in_valid = 1'b1; w_x = a; w_y = b; w_sub = s; w_out_ready = 1'b1;
        chk({nm, "_in_ready"}, {31'd0, w_in_ready}, 32'd1);
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        n = 0;
        while (!w_out_valid && n < 30) begin
            @(posedge clk); #1; n++;
        end
        chk({nm, "_latency"}, n, 32'd4);
        chk({nm, "_out"}, {16'd0, w_out}, {16'd0, eo});
        chk({nm, "_flags"}, {30'd0, w_cout, w_ovf}, {30'd0, ec, ev});
        @(posedge clk); #1;
    endtask

    vec_t tbl[8];

    initial begin
        int n, idx, got, cyc, last;
        res_t exp_q[$];
        res_t e;
        logic [7:0] ra, rb;
        logic       rs;

        tbl[0] = '{8'h0D, 8'h06, 1'b0, 8'h13, 1'b0, 1'b0};
        tbl[2] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
        tbl[4] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[6] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
`ifdef ADD_SAT_EN
        tbl[1] = '{8'h80, 8'h90, 1'b0, 8'h80, 1'b1, 1'b1};
        tbl[3] = '{8'h7F, 8'hFF, 1'b1, 8'h7F, 1'b0, 1'b1};
        tbl[5] = '{8'h7F, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        tbl[7] = '{8'h80, 8'h01, 1'b1, 8'h80, 1'b1, 1'b1};
`else
        tbl[1] = '{8'h80, 8'h90, 1'b0, 8'h10, 1'b1, 1'b1};
        tbl[3] = '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1};
        tbl[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[7] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
`endif

        rst = 1'b1;
        in_valid = 1'b0; x = '0; y = '0; sub = 1'b0; out_ready = 1'b0;
        w_in_valid = 1'b0; w_x = '0; w_y = '0; w_sub = 1'b0; w_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_outputs", {21'd0, out_valid, out, cout, ovf}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 8; i++)
            do_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].eo, tbl[i].ec, tbl[i].ev, 0, $sformatf("vec%0d", i));

        // Backpressure: pending operands must wait until the held result is taken
        in_valid = 1'b1; x = 8'h12; y = 8'h34; sub = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_vld(n);
        in_valid = 1'b1; x = 8'h55; y = 8'h11;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold", {22'd0, out_valid, in_ready, out}, {22'd0, 1'b1, 1'b0, 8'h46});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_vld(n);
        chk("bp_pending_out", {24'd0, out}, 32'h66);
        @(posedge clk); #1;

        // Reset one cycle after accept discards the in-flight result
        in_valid = 1'b1; x = 8'h33; y = 8'h44; sub = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mid_busy", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_state", {22'd0, in_ready, out_valid, out}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("mid_rst_idle", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
        end
        do_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 0, "after_rst");

        // Random operands with random consumer stalls
        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
            e = model(ra, rb, rs);
            do_op(ra, rb, rs, e.o, e.c, e.v, $urandom_range(0, 2), $sformatf("rnd%0d", i));
        end

        // Streaming: results must arrive every NCHUNK+2 cycles
        idx = 0; got = 0; cyc = 0; last = -1;
        in_valid = 1'b1; out_ready = 1'b1;
        while (got < 4 && cyc < 80) begin
            if (out_valid) begin
                e = exp_q.pop_front();
                chk("stream_out", {22'd0, out, cout, ovf}, {22'd0, e.o, e.c, e.v});
                if (last >= 0) chk("stream_spacing", cyc - last, 32'd4);
                last = cyc;
                got++;
            end
            if (in_ready) begin
                if (idx < 4) begin
                    x = 8'($urandom); y = 8'($urandom); sub = 1'($urandom);
                    exp_q.push_back(model(x, y, sub));
                    idx++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        chk("stream_count", got, 32'd4);
        repeat (3) @(posedge clk);
        #1;

        do16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "w16_wrap");
`ifdef ADD_SAT_EN
        do16(16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, "w16_ovf");
`else
        do16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "w16_ovf");
`endif
        do16(16'h1234, 16'h1235, 1'b1, 16'hFFFF, 1'b0, 1'b0, "w16_sub");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
